// File: rtl/irq_dispatch_seq_if.sv
// Signal bundle between the SM83 decoder/interrupt logic and the dispatch sequencer.
// The master drives the sampling inputs and the slave (the sequencer) drives strobes and pulses.
interface irq_dispatch_seq_if;
    logic       mstep;
    logic       boundary;
    logic       halted;
    logic       ime;
    logic [4:0] ie;
    logic [4:0] iflag;
    logic       busy;
    logic       oe_sp_to_idu;
    logic       wren_sp;
    logic       oe_pch_to_pbus;
    logic       oe_pcl_to_pbus;
    logic       mem_wr;
    logic       wren_pc;
    logic [4:0] bro;
    logic       ime_clr;
    logic [4:0] if_clr;
    logic       halt_exit;
    logic [2:0] dbg_state;

    modport master (
        output mstep, boundary, halted, ime, ie, iflag,
        input  busy, oe_sp_to_idu, wren_sp, oe_pch_to_pbus, oe_pcl_to_pbus,
               mem_wr, wren_pc, bro, ime_clr, if_clr, halt_exit, dbg_state
    );

    modport slave (
        input  mstep, boundary, halted, ime, ie, iflag,
        output busy, oe_sp_to_idu, wren_sp, oe_pch_to_pbus, oe_pcl_to_pbus,
               mem_wr, wren_pc, bro, ime_clr, if_clr, halt_exit, dbg_state
    );
endinterface

// File: rtl/irq_dispatch_seq.sv
// SM83 interrupt dispatch sequencer: dead cycle, SP decrement, PCH/PCL push, vector jump.
// Strobes are Moore-decoded from the state; ime_clr, if_clr and halt_exit are registered pulses.
module irq_dispatch_seq #(
    parameter int NIRQ = 5
) (
    input logic               CLK,
    input logic               nRES,
    irq_dispatch_seq_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W1     = 3'd1;
    localparam logic [2:0] S_DEC    = 3'd2;
    localparam logic [2:0] S_PUSH_H = 3'd3;
    localparam logic [2:0] S_PUSH_L = 3'd4;
    localparam logic [2:0] S_JUMP   = 3'd5;

    logic [2:0] state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic       ime_clr_q, ime_clr_d;
    logic [4:0] if_clr_q, if_clr_d;
    logic       halt_exit_q, halt_exit_d;

    logic [4:0] pend;
    logic       any;
    logic [2:0] low_idx;
    logic [4:0] low_oh;

    // Lowest-numbered pending source has priority.
    always_comb begin
        pend    = bus.ie & bus.iflag;
        any     = |pend;
        low_idx = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pend[i]) low_idx = 3'(i);
        end
        low_oh = pend & (~pend + 5'd1);
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        ime_clr_d   = 1'b0;
        if_clr_d    = 5'd0;
        halt_exit_d = 1'b0;
        if (bus.mstep) begin
            halt_exit_d = bus.halted & any;
            case (state_q)
                S_IDLE: begin
                    if (bus.ime & any & (bus.boundary | bus.halted)) begin
                        state_d   = S_W1;
                        ime_clr_d = 1'b1;
                    end
                end
                S_W1:     state_d = S_DEC;
                S_DEC:    state_d = S_PUSH_H;
                S_PUSH_H: state_d = S_PUSH_L;
                S_PUSH_L: begin
                    // Resample decides the vector; an empty resample cancels to 0x0000.
                    state_d = S_JUMP;
                    if (any) begin
                        vec_d    = {2'b01, low_idx};
                        if_clr_d = low_oh;
                    end else begin
                        vec_d = 5'd0;
                    end
                end
                S_JUMP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q     <= S_IDLE;
            vec_q       <= 5'd0;
            ime_clr_q   <= 1'b0;
            if_clr_q    <= 5'd0;
            halt_exit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            ime_clr_q   <= ime_clr_d;
            if_clr_q    <= if_clr_d;
            halt_exit_q <= halt_exit_d;
        end
    end

    always_comb begin
        bus.busy           = (state_q != S_IDLE);
        bus.oe_sp_to_idu   = (state_q == S_DEC) || (state_q == S_PUSH_H);
        bus.wren_sp        = (state_q == S_DEC) || (state_q == S_PUSH_H);
        bus.oe_pch_to_pbus = (state_q == S_PUSH_H);
        bus.oe_pcl_to_pbus = (state_q == S_PUSH_L);
        bus.mem_wr         = (state_q == S_PUSH_H) || (state_q == S_PUSH_L);
        bus.wren_pc        = (state_q == S_JUMP);
        bus.bro            = (state_q == S_JUMP) ? vec_q : 5'd0;
    end

    assign bus.ime_clr   = ime_clr_q;
    assign bus.if_clr    = if_clr_q;
    assign bus.halt_exit = halt_exit_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Bench for irq_dispatch_seq: directed scenarios plus randomized M-cycle traffic
// compared against a phase-counting model of the dispatch sequence.
module tb_irq_dispatch_seq;

    logic CLK;
    logic nRES;
    irq_dispatch_seq_if bus();

    irq_dispatch_seq #(.NIRQ(5)) dut (
        .CLK  (CLK),
        .nRES (nRES),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = idle, 1..5 = the five M-cycles of a dispatch.
    int         m_phase;
    logic [4:0] m_vec;
    logic       m_ime_clr;
    logic [4:0] m_if_clr;
    logic       m_halt;

    logic [18:0] obs;
    logic [18:0] exp;

    // {busy, oe_sp, wren_sp, oe_pch, oe_pcl, mem_wr, wren_pc}
    function automatic logic [6:0] phase_strobes(input int p);
        case (p)
            1:       return 7'b1000000;
            2:       return 7'b1110000;
            3:       return 7'b1111010;
            4:       return 7'b1000110;
            5:       return 7'b1000001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [18:0] model_out();
        return {phase_strobes(m_phase), (m_phase == 5) ? m_vec : 5'd0,
                m_ime_clr, m_if_clr, m_halt};
    endfunction

    function automatic logic [18:0] dut_out();
        return {bus.busy, bus.oe_sp_to_idu, bus.wren_sp, bus.oe_pch_to_pbus,
                bus.oe_pcl_to_pbus, bus.mem_wr, bus.wren_pc, bus.bro,
                bus.ime_clr, bus.if_clr, bus.halt_exit};
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_vec     = 5'd0;
        m_ime_clr = 1'b0;
        m_if_clr  = 5'd0;
        m_halt    = 1'b0;
    endtask

    task automatic model_step();
        int  pend;
        int  n;
        bit  found;
        pend      = int'(bus.ie) & int'(bus.iflag);
        m_halt    = bus.halted && (pend != 0);
        m_ime_clr = 1'b0;
        m_if_clr  = 5'd0;
        if (m_phase == 0) begin
            if (bus.ime && pend != 0 && (bus.boundary || bus.halted)) begin
                m_phase   = 1;
                m_ime_clr = 1'b1;
            end
        end else if (m_phase == 4) begin
            found = 0;
            n     = 0;
            for (int k = 0; k < 5; k++) begin
                if (!found && ((pend >> k) & 1) == 1) begin
                    n     = k;
                    found = 1;
                end
            end
            if (found) begin
                m_vec    = 5'((64 + 8 * n) >> 3);
                m_if_clr = 5'(1 << n);
            end else begin
                m_vec = 5'd0;
            end
            m_phase = 5;
        end else if (m_phase == 5) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    // One CLK with mstep high; inputs must already be set.
    task automatic advance();
        model_step();
        bus.mstep = 1'b1;
        @(posedge CLK);
        #1;
        bus.mstep = 1'b0;
    endtask

    task automatic quiet_clk();
        m_ime_clr = 1'b0;
        m_if_clr  = 5'd0;
        m_halt    = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_inputs(input logic [4:0] ie_v, input logic [4:0] if_v,
                              input logic ime_v, input logic bnd_v, input logic hlt_v);
        bus.ie       = ie_v;
        bus.iflag    = if_v;
        bus.ime      = ime_v;
        bus.boundary = bnd_v;
        bus.halted   = hlt_v;
    endtask

    task automatic test_reset();
        nRES = 1'b0;
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.mstep = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        obs = dut_out();
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 19'd0);
        end
        nRES = 1'b1;
        set_inputs(5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0);
        quiet_clk();
        obs = dut_out();
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_release_no_mstep: got %h expected %h", obs, 19'd0);
        end
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic_dispatch();
        set_inputs(5'h1F, 5'h04, 1'b1, 1'b1, 1'b0);
        advance();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL basic_enter: got %h expected %h", obs, exp);
        end
        checks++;
        if (bus.ime_clr !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_ime_clr: got %b/%b expected 1/1", bus.ime_clr, bus.busy);
        end
        bus.boundary = 1'b0;
        quiet_clk();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL basic_pulse_width: got %h expected %h", obs, exp);
        end
        for (int e = 2; e <= 6; e++) begin
            advance();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL basic_edge%0d: got %h expected %h", e, obs, exp);
            end
            if (e == 5) begin
                checks++;
                if (bus.if_clr !== 5'h04 || bus.bro !== 5'b01010 || bus.wren_pc !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_jump: got if_clr=%h bro=%b wren_pc=%b expected 04 01010 1",
                             bus.if_clr, bus.bro, bus.wren_pc);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_latency: got busy=%b expected 0", bus.busy);
        end
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_preempt();
        set_inputs(5'h1F, 5'h10, 1'b1, 1'b1, 1'b0);
        advance();
        bus.boundary = 1'b0;
        advance();
        advance();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL preempt_push_h: got %h expected %h", obs, exp);
        end
        bus.iflag = 5'h11;
        advance();
        advance();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL preempt_jump: got %h expected %h", obs, exp);
        end
        checks++;
        if (bus.bro !== 5'b01000 || bus.if_clr !== 5'h01) begin
            errors++;
            $display("FAIL preempt_vector: got bro=%b if_clr=%h expected 01000 01", bus.bro, bus.if_clr);
        end
        advance();
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cancel();
        set_inputs(5'h1F, 5'h02, 1'b1, 1'b1, 1'b0);
        advance();
        bus.boundary = 1'b0;
        advance();
        advance();
        bus.ie = 5'h00;
        advance();
        advance();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL cancel_jump: got %h expected %h", obs, exp);
        end
        checks++;
        if (bus.bro !== 5'd0 || bus.if_clr !== 5'd0 || bus.wren_pc !== 1'b1) begin
            errors++;
            $display("FAIL cancel_vector: got bro=%b if_clr=%h wren_pc=%b expected 00000 00 1",
                     bus.bro, bus.if_clr, bus.wren_pc);
        end
        advance();
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_halt_no_ime();
        set_inputs(5'h1F, 5'h08, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            advance();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL halt_step%0d: got %h expected %h", k, obs, exp);
            end
            checks++;
            if (bus.halt_exit !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL halt_pulse%0d: got halt_exit=%b busy=%b expected 1 0", k, bus.halt_exit, bus.busy);
            end
            quiet_clk();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL halt_gap%0d: got %h expected %h", k, obs, exp);
            end
        end
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_inputs(5'h1F, 5'h01, 1'b1, 1'b1, 1'b0);
        advance();
        bus.boundary = 1'b0;
        advance();
        advance();
        nRES = 1'b0;
        #1;
        model_reset();
        obs = dut_out(); checks++;
        if (obs !== 19'd0) begin
            errors++; $display("FAIL reset_mid_async: got %h expected %h", obs, 19'd0);
        end
        @(posedge CLK);
        #1;
        nRES = 1'b1;
        for (int k = 0; k < 2; k++) begin
            advance();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL reset_mid_idle%0d: got %h expected %h", k, obs, exp);
            end
        end
        bus.boundary = 1'b1;
        advance();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_mid_restart: got %h expected %h", obs, exp);
        end
        bus.boundary = 1'b0;
        repeat (5) advance();
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ime_off();
        set_inputs(5'h1F, 5'h06, 1'b0, 1'b1, 1'b0);
        advance();
        obs = dut_out(); exp = model_out(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL ime_off: got %h expected %h", obs, exp);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL ime_off_busy: got %b expected 0", bus.busy);
        end
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_inputs(5'h01, 5'h01, 1'b1, 1'b1, 1'b0);
        for (int e = 1; e <= 7; e++) begin
            advance();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b_edge%0d: got %h expected %h", e, obs, exp);
            end
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.ime_clr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reenter: got busy=%b ime_clr=%b expected 1 1", bus.busy, bus.ime_clr);
        end
        bus.boundary = 1'b0;
        repeat (5) advance();
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int gap;
        for (int it = 0; it < 300; it++) begin
            set_inputs(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) == 0));
            advance();
            obs = dut_out(); exp = model_out(); checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL random_step%0d: got %h expected %h", it, obs, exp);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.ie    = 5'($urandom_range(0, 31));
                bus.iflag = 5'($urandom_range(0, 31));
                quiet_clk();
                obs = dut_out(); exp = model_out(); checks++;
                if (obs !== exp) begin
                    errors++; $display("FAIL random_gap%0d: got %h expected %h", it, obs, exp);
                end
            end
        end
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (6) advance();
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_preempt();
        test_cancel();
        test_halt_no_ime();
        test_reset_mid();
        test_ime_off();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
